// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_subtractor_if : request/result bundle of serial_subtractor |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_subtractor : bit-serial a - b - bin, LSB first, one bit/clk |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    serial_subtractor_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;

    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign w_accept  = bus.start && (r_state != SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = SHIFT;
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? SHIFT : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_br  <= bus.bin;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            // Only the completed word is published; partial results stay internal.
            if (w_last) begin
                r_diff <= {w_d, r_res[WIDTH-1:1]};
                r_bout <= w_br_next;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_serial_subtractor : directed and random checks, WIDTH = 8      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          output logic [7:0] od, output logic ob,
                          output int nbusy, output bit tmo);
        @(negedge clk);
        bus.a     = ia;
        bus.b     = ib;
        bus.bin   = ibin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0;
        tmo   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                tmo = 1'b0;
                break;
            end
            if (bus.busy) nbusy++;
            @(negedge clk);
        end
        od = bus.diff;
        ob = bus.bout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b required all 0",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] d; logic bo; int nb; bit tmo;
        run_op(8'h05, 8'h03, 1'b0, d, bo, nb, tmo);
        checks++;
        if (tmo || nb !== 8) begin
            failures++;
            $display("FAIL basic_busy: busy_cycles=%0d timeout=%0b required 8/0", nb, tmo);
        end
        checks++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: diff=%h bout=%b required 02/0", d, bo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_width: done=%b busy=%b required 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic bo; int nb; bit tmo;
        run_op(8'h00, 8'h01, 1'b0, d, bo, nb, tmo);
        checks++;
        if (tmo || d !== 8'hFF || bo !== 1'b1) begin
            failures++;
            $display("FAIL wrap_00_01: diff=%h bout=%b timeout=%0b required FF/1/0", d, bo, tmo);
        end
        run_op(8'h80, 8'h7F, 1'b1, d, bo, nb, tmo);
        checks++;
        if (tmo || d !== 8'h00 || bo !== 1'b0) begin
            failures++;
            $display("FAIL wrap_80_7f_b1: diff=%h bout=%b timeout=%0b required 00/0/0", d, bo, tmo);
        end
        run_op(8'h00, 8'hFF, 1'b1, d, bo, nb, tmo);
        checks++;
        if (tmo || d !== 8'h00 || bo !== 1'b1) begin
            failures++;
            $display("FAIL wrap_00_ff_b1: diff=%h bout=%b timeout=%0b required 00/1/0", d, bo, tmo);
        end
    endtask

    task automatic test_start_ignored();
        int ndone; logic [7:0] d; logic bo;
        ndone = 0; d = 8'h00; bo = 1'b1;
        @(negedge clk);
        bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                d  = bus.diff;
                bo = bus.bout;
            end
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: dones=%0d required 1", ndone);
        end
        checks++;
        if (d !== 8'h0F || bo !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: diff=%h bout=%b required 0F/0", d, bo);
        end
    endtask

    task automatic test_reset_abort();
        int ndone; bit leak; logic [7:0] d; logic bo; int nb; bit tmo;
        ndone = 0; leak = 1'b0;
        @(negedge clk);
        bus.a = 8'h55; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.bout !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate: busy=%b done=%b diff=%h bout=%b required 0/0/00/0",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.diff !== 8'h00) leak = 1'b1;
        end
        checks++;
        if (ndone !== 0 || leak) begin
            failures++;
            $display("FAIL abort_no_done: dones=%0d diff_changed=%0b required 0/0", ndone, leak);
        end
        run_op(8'h55, 8'h11, 1'b0, d, bo, nb, tmo);
        checks++;
        if (tmo || d !== 8'h44 || bo !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: diff=%h bout=%b timeout=%0b required 44/0/0", d, bo, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int ndone; int cyc; int last;
        ndone = 0; last = -1;
        @(negedge clk);
        bus.a = 8'h03; bus.b = 8'h04; bus.bin = 1'b0; bus.start = 1'b1;
        for (cyc = 0; cyc < 60 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                checks++;
                if (bus.diff !== 8'hFF || bus.bout !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_result: diff=%h bout=%b required FF/1", bus.diff, bus.bout);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 9) begin
                        failures++;
                        $display("FAIL b2b_period: period=%0d required 9", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone !== 4) begin
            failures++;
            $display("FAIL b2b_count: dones=%0d required 4", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, d, ed; logic rbin, bo, eb; int nb; bit tmo; int ei;
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            ei   = int'(ra) - int'(rb) - int'(rbin);
            ed   = ei[7:0];
            eb   = (ei < 0);
            run_op(ra, rb, rbin, d, bo, nb, tmo);
            checks++;
            if (tmo || d !== ed || bo !== eb) begin
                failures++;
                $display("FAIL random: a=%h b=%h bin=%b diff=%h bout=%b timeout=%0b required %h/%b/0",
                         ra, rb, rbin, d, bo, tmo, ed, eb);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.bin   = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
